// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output stream among REQ requesters.
// Locked multi-beat bursts; define ARB_BURST_LIMIT_EN to cap bursts at MAX_BURST beats.
module rr_stream_arbiter #(
  parameter int REQ       = 4,
  parameter int DATA      = 32,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = (REQ > 1) ? $clog2(REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REQ-1:0]           req_valid,
  input  logic [REQ-1:0][DATA-1:0] req_data,
  input  logic [REQ-1:0]           req_last,
  output logic [REQ-1:0]           req_ready,
  output logic                     out_valid,
  output logic [DATA-1:0]          out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int unsigned REQ_U = REQ;

  if (REQ < 1 || MAX_BURST < 1) begin : g_bad_params
    $error("rr_stream_arbiter: REQ and MAX_BURST must be >= 1");
  end

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state, state_n;
  logic [ID_W-1:0] ptr, ptr_n;
  logic [ID_W-1:0] lock_id, lock_n;
  logic [ID_W-1:0] grant_id, ptr_adv, cand;
  logic            grant_valid;
  logic            load, accept;
  int unsigned     idx;

`ifdef ARB_BURST_LIMIT_EN
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
  logic [CNT_W-1:0] cnt, cnt_n, beat_num;
`endif

  assign load    = !out_valid || out_ready;
  assign accept  = load && grant_valid;
  assign ptr_adv = (grant_id == ID_W'(REQ - 1)) ? '0 : grant_id + ID_W'(1);

  // Upward search from ptr with wrap; in LOCK only the locked requester may win.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    cand        = '0;
    if (state == LOCK) begin
      if (req_valid[lock_id]) begin
        grant_valid = 1'b1;
        grant_id    = lock_id;
      end
    end else begin
      for (int unsigned k = 0; k < REQ_U; k++) begin
        idx  = (32'(ptr) + k) % REQ_U;
        cand = ID_W'(idx);
        if (!grant_valid && req_valid[cand]) begin
          grant_valid = 1'b1;
          grant_id    = cand;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    lock_n  = lock_id;
`ifdef ARB_BURST_LIMIT_EN
    beat_num = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
    cnt_n    = cnt;
`endif
    if (accept) begin
      if (req_last[grant_id]) begin
        state_n = IDLE;
        ptr_n   = ptr_adv;
      end else begin
        state_n = LOCK;
        lock_n  = grant_id;
`ifdef ARB_BURST_LIMIT_EN
        if (beat_num == CNT_W'(MAX_BURST)) begin
          state_n = IDLE;
          ptr_n   = ptr_adv;
        end
`endif
      end
`ifdef ARB_BURST_LIMIT_EN
      cnt_n = (state_n == LOCK) ? beat_num : '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      lock_id <= '0;
`ifdef ARB_BURST_LIMIT_EN
      cnt     <= '0;
`endif
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      lock_id <= lock_n;
`ifdef ARB_BURST_LIMIT_EN
      cnt     <= cnt_n;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= req_data[grant_id];
        out_id    <= grant_id;
        out_last  <= req_last[grant_id];
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
    busy = (state == LOCK);
  end

endmodule
